// File: rtl/nios2system_onchip_ram_pipelined.sv
// Single-port on-chip RAM behind an Avalon-MM slave: byte-lane writes, pipelined reads
// with readdatavalid, and an optional clear sweep of every word after reset.
//   state    | meaning
//   ST_CLEAR | sweeping CLEAR_VALUE into mem[clr_ptr], bus held off with waitrequest
//   ST_RUN   | in service; accepts one read or write per enabled cycle
module nios2system_onchip_ram_pipelined #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 14,
    parameter int                    DEPTH          = 16384,
    parameter int                    READ_LATENCY   = 2,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_WIDTH/8-1:0]   byteenable,
    input  logic                      chipselect,
    input  logic                      read,
    input  logic                      write,
    input  logic [DATA_WIDTH-1:0]     writedata,
    input  logic                      clken,
    output logic [DATA_WIDTH-1:0]     readdata,
    output logic                      readdatavalid,
    output logic                      waitrequest,
    output logic                      init_done
);

    localparam int                    BE_W     = DATA_WIDTH / 8;
    localparam int                    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      clr_ptr_q, clr_ptr_d;
    logic                  s1_vld_q, s1_vld_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  rdv_q, rdv_d;
    logic [DATA_WIDTH-1:0] readdata_q, readdata_d;

    logic                  run;
    logic                  addr_ok;
    logic [IDX_W-1:0]      addr_idx;
    logic                  req_ok;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  mem_we;
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [BE_W-1:0]       mem_be;

    assign run      = (state_q == ST_RUN);
    assign addr_ok  = ({1'b0, address} < DEPTH_L);
    assign addr_idx = address[IDX_W-1:0];
    assign req_ok   = chipselect & clken & run & ~reset;
    assign wr_acc   = req_ok & write;
    // A simultaneous write takes the slot, so the read is dropped entirely.
    assign rd_acc   = req_ok & read & ~write;
    assign rd_word  = addr_ok ? mem[addr_idx] : '0;

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        s1_vld_d   = s1_vld_q;
        s1_data_d  = s1_data_q;
        rdv_d      = rdv_q;
        readdata_d = readdata_q;
        mem_we     = 1'b0;
        mem_idx    = addr_idx;
        mem_wdata  = writedata;
        mem_be     = byteenable;

        if (clken) begin
            if (state_q == ST_CLEAR) begin
                mem_we    = ~reset;
                mem_idx   = clr_ptr_q;
                mem_wdata = CLEAR_VALUE;
                mem_be    = '1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_IDX) begin
                    state_d   = ST_RUN;
                    clr_ptr_d = '0;
                end
            end else if (wr_acc && addr_ok) begin
                mem_we = 1'b1;
            end

            if (READ_LATENCY == 1) begin
                rdv_d = rd_acc;
                if (rd_acc) readdata_d = rd_word;
            end else begin
                s1_vld_d = rd_acc;
                if (rd_acc) s1_data_d = rd_word;
                rdv_d = s1_vld_q;
                if (s1_vld_q) readdata_d = s1_data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            clr_ptr_q  <= '0;
            s1_vld_q   <= 1'b0;
            s1_data_q  <= '0;
            rdv_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            s1_vld_q   <= s1_vld_d;
            s1_data_q  <= s1_data_d;
            rdv_q      <= rdv_d;
            readdata_q <= readdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // A pending valid stays latched while frozen and shows up in the next enabled cycle.
    assign readdata      = readdata_q;
    assign readdatavalid = rdv_q & clken;
    assign waitrequest   = ~run | reset;
    assign init_done     = run & ~reset;

endmodule
